// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and grant-source encoding for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_REG_SEL_BITS = 5;
  localparam int unsigned DEF_FIFO_DEPTH   = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_src_e;

  // Bits needed to hold any value in 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Requester-B writeback queue: in-order storage with per-entry reg/valid export for hazard checks.
module wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned REG_SEL_BITS = DEF_REG_SEL_BITS,
  parameter int unsigned DEPTH        = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [REG_SEL_BITS-1:0]         push_reg,
  input  logic [DATA_WIDTH-1:0]           push_data,
  input  logic                            pop,
  output logic [REG_SEL_BITS-1:0]         head_reg,
  output logic [DATA_WIDTH-1:0]           head_data,
  output logic                            full,
  output logic                            empty,
  output logic [cnt_width(DEPTH)-1:0]     count,
  output logic [DEPTH*REG_SEL_BITS-1:0]   entry_reg,
  output logic [DEPTH-1:0]                entry_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [REG_SEL_BITS-1:0] reg_q  [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]        valid_q, valid_nxt;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_nxt;
  logic                    full_q, empty_q;

  // Occupancy and per-slot valid bits after this cycle's push/pop.
  always_comb begin
    valid_nxt = valid_q;
    count_nxt = CW'(count_q + CW'(push) - CW'(pop));
    if (pop) begin
      valid_nxt[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      valid_nxt[wr_ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) begin
        reg_q[wr_ptr_q]  <= push_reg;
        data_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      valid_q <= valid_nxt;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  assign head_reg    = reg_q[rd_ptr_q];
  assign head_data   = data_q[rd_ptr_q];
  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign entry_valid = valid_q;

  always_comb begin
    entry_reg = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_reg[i*REG_SEL_BITS +: REG_SEL_BITS] = reg_q[i];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the pipeline writeback (A) and a queued long-latency unit (B) onto one
// register-file write port, with starvation relief for B and a decode read-hazard stall.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned REG_SEL_BITS = DEF_REG_SEL_BITS,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [REG_SEL_BITS-1:0] a_reg,
  input  logic [DATA_WIDTH-1:0]   a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [REG_SEL_BITS-1:0] b_reg,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    write,
  output logic [REG_SEL_BITS-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]   write_data,
  input  logic [REG_SEL_BITS-1:0] rs1,
  input  logic [REG_SEL_BITS-1:0] rs2,
  output logic                    stall
);

  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam int unsigned SW = cnt_width(STARVE_LIMIT);

  logic                               fifo_full, fifo_empty;
  logic [CW-1:0]                      fifo_count, count_nxt;
  logic [REG_SEL_BITS-1:0]            head_reg;
  logic [DATA_WIDTH-1:0]              head_data;
  logic [FIFO_DEPTH*REG_SEL_BITS-1:0] entry_reg;
  logic [FIFO_DEPTH-1:0]              entry_valid;

  logic       a_fire, b_enq, b_deq;
  grant_src_e grant;
  logic [SW-1:0] starve_q, starve_nxt;
  logic          a_ready_q, a_ready_nxt;

  assign a_ready = a_ready_q;
  assign b_ready = !fifo_full;
  assign a_fire  = a_valid && a_ready_q;
  assign b_enq   = b_valid && !fifo_full;
  assign b_deq   = (grant == GRANT_B);

  // A wins whenever it transfers; B takes every otherwise-idle slot.
  always_comb begin
    grant = GRANT_NONE;
    if (a_fire) begin
      grant = GRANT_A;
    end else if (!fifo_empty) begin
      grant = GRANT_B;
    end
  end

  // a_ready is kept as a flop holding the next cycle's "no forced B grant".
  always_comb begin
    starve_nxt = starve_q;
    count_nxt  = CW'(fifo_count + CW'(b_enq) - CW'(b_deq));
    if (b_deq || fifo_empty) begin
      starve_nxt = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_nxt = starve_q + SW'(1);
    end
    a_ready_nxt = !((starve_nxt == SW'(STARVE_LIMIT)) && (count_nxt != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      a_ready_q <= 1'b1;
    end else begin
      starve_q  <= starve_nxt;
      a_ready_q <= a_ready_nxt;
    end
  end

  // Register-file write port; an x0 grant updates reg/data but never asserts write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write      <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      unique case (grant)
        GRANT_A: begin
          write      <= (a_reg != '0);
          write_reg  <= a_reg;
          write_data <= a_data;
        end
        GRANT_B: begin
          write      <= (head_reg != '0);
          write_reg  <= head_reg;
          write_data <= head_data;
        end
        default: begin
          write <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic src_hit(input logic [REG_SEL_BITS-1:0] rs,
                                   input logic [REG_SEL_BITS-1:0] wr);
    return (rs != '0) && (rs == wr);
  endfunction

  // Hazard: a decode source names a register still queued in B or on the write port.
  always_comb begin
    stall = write && (src_hit(rs1, write_reg) || src_hit(rs2, write_reg));
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (entry_valid[i] &&
          (src_hit(rs1, entry_reg[i*REG_SEL_BITS +: REG_SEL_BITS]) ||
           src_hit(rs2, entry_reg[i*REG_SEL_BITS +: REG_SEL_BITS]))) begin
        stall = 1'b1;
      end
    end
  end

  wb_fifo #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_SEL_BITS (REG_SEL_BITS),
    .DEPTH        (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (b_enq),
    .push_reg    (b_reg),
    .push_data   (b_data),
    .pop         (b_deq),
    .head_reg    (head_reg),
    .head_data   (head_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_reg   (entry_reg),
    .entry_valid (entry_valid)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter against a queue-based behavioural model.
module tb_regfile_write_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned RS    = 5;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [RS-1:0] a_reg, b_reg, write_reg, rs1, rs2;
  logic [DW-1:0] a_data, b_data, write_data;
  logic          write, stall;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_WIDTH   (DW),
    .REG_SEL_BITS (RS),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_reg      (a_reg),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_reg      (b_reg),
    .b_data     (b_data),
    .write      (write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .stall      (stall)
  );

  typedef struct {
    logic [RS-1:0] rg;
    logic [DW-1:0] dt;
  } bent_t;

  typedef struct {
    int unsigned   stamp;
    logic          wr;
    logic [RS-1:0] rg;
    logic [DW-1:0] dt;
  } exp_t;

  bent_t         mq[$];
  exp_t          sb[$];
  exp_t          mon_x;
  int unsigned   waited;
  logic          out_write;
  logic [RS-1:0] out_reg;
  logic [RS-1:0] held_reg;
  logic [DW-1:0] held_data;
  int unsigned   edge_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic stall_of(input logic [RS-1:0] rs);
    if (rs == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].rg == rs) return 1'b1;
    return out_write && (out_reg == rs);
  endfunction

  // One cycle: apply inputs at negedge, check handshakes/stall, advance the model.
  task automatic drive_cycle(input logic av, input logic [RS-1:0] ar, input logic [DW-1:0] ad,
                             input logic bv, input logic [RS-1:0] br, input logic [DW-1:0] bd,
                             input logic [RS-1:0] r1, input logic [RS-1:0] r2);
    logic  exp_ar, exp_br, fire, enq, deq, was_empty;
    bent_t e;
    exp_t  x;
    @(negedge clk);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    rs1 = r1; rs2 = r2;
    #1;
    was_empty = (mq.size() == 0);
    exp_br = (mq.size() < DEPTH);
    exp_ar = !((waited == LIMIT) && !was_empty);
    check("a_ready", 32'(a_ready), 32'(exp_ar));
    check("b_ready", 32'(b_ready), 32'(exp_br));
    check("stall", 32'(stall), 32'(stall_of(r1) || stall_of(r2)));
    fire = av && exp_ar;
    enq  = bv && exp_br;
    deq  = !fire && !was_empty;
    x = '{stamp: 0, wr: 1'b0, rg: '0, dt: '0};
    if (fire) begin
      x = '{stamp: edge_cnt + 1, wr: (ar != '0), rg: ar, dt: ad};
    end else if (deq) begin
      e = mq.pop_front();
      x = '{stamp: edge_cnt + 1, wr: (e.rg != '0), rg: e.rg, dt: e.dt};
    end
    if (fire || deq) begin
      sb.push_back(x);
      out_write = x.wr;
      out_reg   = x.rg;
    end else begin
      out_write = 1'b0;
    end
    if (deq || was_empty) waited = 0;
    else if (waited < LIMIT) waited++;
    if (enq) begin
      e.rg = br; e.dt = bd;
      mq.push_back(e);
    end
  endtask

  task automatic idle(input int n, input logic [RS-1:0] r1, input logic [RS-1:0] r2);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
  endtask

  task automatic do_reset(input logic [RS-1:0] r1, input logic [RS-1:0] r2);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; rs1 = r1; rs2 = r2;
    rst_n = 1'b0;
    #1;
    check("reset write", 32'(write), 32'd0);
    check("reset b_ready", 32'(b_ready), 32'd1);
    check("reset a_ready", 32'(a_ready), 32'd1);
    check("reset stall", 32'(stall), 32'd0);
    mq.delete(); sb.delete();
    waited = 0; out_write = 1'b0; out_reg = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle either a predicted grant lands or the write port must idle and hold.
  initial begin
    held_reg = '0; held_data = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        check("rst write", 32'(write), 32'd0);
        check("rst write_reg", 32'(write_reg), 32'd0);
        check("rst write_data", write_data, 32'd0);
        held_reg = '0; held_data = '0;
      end else if (sb.size() > 0 && sb[0].stamp <= edge_cnt) begin
        mon_x = sb.pop_front();
        check("grant latency", edge_cnt, mon_x.stamp);
        check("write", 32'(write), 32'(mon_x.wr));
        check("write_reg", 32'(write_reg), 32'(mon_x.rg));
        check("write_data", write_data, mon_x.dt);
        held_reg = mon_x.rg; held_data = mon_x.dt;
      end else begin
        check("idle write", 32'(write), 32'd0);
        check("hold write_reg", 32'(write_reg), 32'(held_reg));
        check("hold write_data", write_data, held_data);
      end
    end
  end

  initial begin
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    rs1 = '0; rs2 = '0;
    waited = 0; out_write = 1'b0; out_reg = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset release.
    idle(2, 5'd3, 5'd4);
    check("idle write after reset", 32'(write), 32'd0);

    // Simultaneous A and B: A first, B on the first A-idle cycle.
    drive_cycle(1'b1, 5'd5, 32'hA5, 1'b1, 5'd7, 32'h77, '0, '0);
    drive_cycle(1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 5'd7, '0);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, '0);
    idle(2, '0, '0);

    // Starvation: B reg 9 waits behind continuous A traffic until forced.
    drive_cycle(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, '0, '0);
    for (int k = 1; k <= 7; k++) begin
      drive_cycle(1'b1, 5'(10 + k), 32'(k), 1'b0, '0, '0, 5'd9, '0);
      if (k == 5) check("forced a_ready low", 32'(a_ready), 32'd0);
      if (k == 6) check("a_ready back after force", 32'(a_ready), 32'd1);
    end
    idle(2, '0, '0);

    // Queue full: regs 3 then 4 accepted, third refused, FIFO-order retire.
    drive_cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33, '0, '0);
    drive_cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44, '0, '0);
    drive_cycle(1'b1, 5'd1, 32'h12, 1'b1, 5'd5, 32'h55, '0, '0);
    check("b_ready low when full", 32'(b_ready), 32'd0);
    for (int k = 0; k < 12; k++) drive_cycle(1'b1, 5'd2, 32'(k), 1'b0, '0, '0, 5'd3, 5'd4);
    idle(2, '0, '0);

    // x0 write, then stall on a queued register until it has been written.
    drive_cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0, '0, '0);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    check("x0 write suppressed", 32'(write), 32'd0);
    drive_cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC, '0, 5'd12);
    drive_cycle(1'b1, 5'd2, 32'h2, 1'b0, '0, '0, '0, 5'd12);
    check("stall while queued", 32'(stall), 32'd1);
    idle(4, '0, 5'd12);

    // Reset with two queued entries discards them.
    drive_cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20, '0, '0);
    drive_cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21, '0, '0);
    do_reset(5'd20, 5'd21);
    idle(8, 5'd20, 5'd21);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      drive_cycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 99) < 40, 5'($urandom_range(0, 15)), $urandom,
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(10, '0, '0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
